// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage in front of opcode_decoder. Owns the program counter,
// issues word-aligned requests to instruction memory over a req/gnt/rvalid
// handshake, buffers returned words with their PCs in an in-order FIFO and
// hands them to decode over a valid/ready handshake. Redirects flush the
// buffer, restart fetch at a new PC and discard responses still in flight.
//
// Parameters
//   RESET_PC        first PC fetched after reset (word aligned)
//   DEPTH           buffer entries; also the cap on buffered + in-flight words
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   reset_i         synchronous active-high reset
//   imem_req_o      fetch request valid
//   imem_addr_o     fetch address (current PC), bits [1:0] always 0
//   imem_gnt_i      memory accepts the request this cycle
//   imem_rvalid_i   response valid (one per granted request, in order)
//   imem_rdata_i    response instruction word
//   redirect_i      flush and restart fetch
//   redirect_pc_i   restart PC, bits [1:0] ignored
//   instr_valid_o   buffer head valid
//   instr_o         buffer head instruction word (0 when not valid)
//   instr_pc_o      PC of the buffer head (0 when not valid)
//   instr_ready_i   decode accepts the head this cycle
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,

    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]   pc_q,       pc_d;
    logic [31:0]   resp_pc_q,  resp_pc_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic [CW-1:0] outst_q,    outst_d;
    logic [CW-1:0] drop_q,     drop_d;

    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic          pop;
    logic          grant;
    logic          resp;
    logic          resp_drop;
    logic          push;
    logic          credit_ok;
    logic [CW:0]   pending;
    logic [31:0]   redirect_pc_al;

    // Low address bits of the redirect target are forced to zero.
    logic          unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    assign redirect_pc_al = {redirect_pc_i[31:2], 2'b00};

    assign instr_valid_o = (count_q != '0);
    assign pop           = instr_valid_o && instr_ready_i;

    // Every buffered word and every in-flight request holds a slot. A pop this
    // cycle frees one, so a full stage can still request when decode drains.
    assign pending   = {1'b0, count_q} + {1'b0, outst_q};
    assign credit_ok = (pending < {1'b0, DEPTH_C}) ||
                       ((pending == {1'b0, DEPTH_C}) && pop);

    assign imem_req_o  = !reset_i && credit_ok;
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding cannot belong to us; ignore it.
    assign resp      = imem_rvalid_i && (outst_q != '0);
    // Responses are stale while drop_q covers them, and any response landing
    // in the redirect cycle is stale by definition.
    assign resp_drop = resp && (redirect_i || (drop_q != '0));
    assign push      = resp && !resp_drop;

    assign instr_o    = instr_valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc_o = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : 32'h0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        outst_d = outst_q;
        case ({grant, resp})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (redirect_i) begin
            // Everything still in flight after this cycle predates the redirect.
            drop_d = outst_d;
        end else if (resp && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_al;
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Responses return in order and stale ones never push, so the PC of each
    // accepted response is simply the next word after the previous one.
    always_comb begin
        resp_pc_d = resp_pc_q;
        if (redirect_i) begin
            resp_pc_d = redirect_pc_al;
        end else if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: the outputs are gated by instr_valid_o.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !redirect_i && push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk_i;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    instr_fetch #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One record per clock cycle: inputs applied in that cycle and the
    // outputs expected before the edge that ends it.
    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic        rdy;
        logic        rdr;
        logic [31:0] rdr_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] gq[$];    // addresses of granted requests, oldest first
    int          n_checks;
    int          n_fail;
    int          cyc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic vec_t mk(input logic rst, input logic gnt, input logic rv,
                                input logic rdy, input logic rdr, input logic [31:0] rdr_pc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdy = rdy;
        v.rdr = rdr; v.rdr_pc = rdr_pc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic vec_t n(input logic gnt, input logic rv, input logic rdy,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_vld, input logic [31:0] e_pc);
        return mk(1'b0, gnt, rv, rdy, 1'b0, 32'h0, e_req, e_addr, e_vld, e_pc);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase of
    // the following cycle.
    task automatic step(input vec_t v);
        logic [31:0] e_instr;
        logic [31:0] e_pcv;
        reset_i       = v.rst;
        imem_gnt_i    = v.gnt;
        imem_rvalid_i = v.rv;
        instr_ready_i = v.rdy;
        redirect_i    = v.rdr;
        redirect_pc_i = v.rdr_pc;
        if (v.rv) begin
            if (gq.size() > 0) imem_rdata_i = word_of(gq.pop_front());
            else               imem_rdata_i = 32'hBAD0_BAD0;
        end else begin
            imem_rdata_i = 32'h0;
        end
        @(negedge clk_i);
        e_instr = v.e_vld ? word_of(v.e_pc) : 32'h0;
        e_pcv   = v.e_vld ? v.e_pc : 32'h0;
        cmp("imem_req_o",    {31'h0, imem_req_o},    {31'h0, v.e_req});
        cmp("imem_addr_o",   imem_addr_o,            v.e_addr);
        cmp("instr_valid_o", {31'h0, instr_valid_o}, {31'h0, v.e_vld});
        cmp("instr_o",       instr_o,                e_instr);
        cmp("instr_pc_o",    instr_pc_o,             e_pcv);
        if (v.rst)                 gq.delete();
        else if (v.gnt && v.e_req) gq.push_back(v.e_addr);
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset_i       = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;

        // reset state
        tbl.push_back(mk(1,0,0,1,0,32'h0, 0,32'h100,0,32'h0));
        // reset fill, 1-cycle memory, ready high
        tbl.push_back(n(1,0,1, 1,32'h100,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'h104,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'h108,1,32'h100));
        tbl.push_back(n(1,1,1, 1,32'h10C,1,32'h104));
        tbl.push_back(n(1,1,1, 1,32'h110,1,32'h108));
        tbl.push_back(n(0,1,1, 1,32'h114,1,32'h10C));
        tbl.push_back(n(0,0,1, 1,32'h114,1,32'h110));
        tbl.push_back(n(0,0,1, 1,32'h114,0,32'h0));
        // backpressure from reset: four requests, then stall with head held
        tbl.push_back(mk(1,0,0,0,0,32'h0, 0,32'h114,0,32'h0));
        tbl.push_back(n(1,0,0, 1,32'h100,0,32'h0));
        tbl.push_back(n(1,1,0, 1,32'h104,0,32'h0));
        tbl.push_back(n(1,1,0, 1,32'h108,1,32'h100));
        tbl.push_back(n(1,1,0, 1,32'h10C,1,32'h100));
        tbl.push_back(n(1,1,0, 0,32'h110,1,32'h100));
        tbl.push_back(n(1,0,0, 0,32'h110,1,32'h100));
        tbl.push_back(n(1,0,0, 0,32'h110,1,32'h100));
        tbl.push_back(n(1,0,1, 1,32'h110,1,32'h100));
        tbl.push_back(n(1,1,1, 1,32'h114,1,32'h104));
        tbl.push_back(n(1,1,1, 1,32'h118,1,32'h108));
        tbl.push_back(n(0,1,1, 1,32'h11C,1,32'h10C));
        tbl.push_back(n(0,0,1, 1,32'h11C,1,32'h110));
        tbl.push_back(n(0,0,1, 1,32'h11C,1,32'h114));
        tbl.push_back(n(0,0,1, 1,32'h11C,1,32'h118));
        tbl.push_back(n(0,0,1, 1,32'h11C,0,32'h0));
        // redirect to 0x2002 with two responses outstanding
        tbl.push_back(mk(1,0,0,1,0,32'h0, 0,32'h11C,0,32'h0));
        tbl.push_back(n(1,0,1, 1,32'h100,0,32'h0));
        tbl.push_back(n(1,0,1, 1,32'h104,0,32'h0));
        tbl.push_back(mk(0,0,0,1,1,32'h2002, 1,32'h108,0,32'h0));
        tbl.push_back(n(0,1,1, 1,32'h2000,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'h2000,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'h2004,0,32'h0));
        tbl.push_back(n(0,1,1, 1,32'h2008,1,32'h2000));
        tbl.push_back(n(0,0,1, 1,32'h2008,1,32'h2004));
        tbl.push_back(n(0,0,1, 1,32'h2008,0,32'h0));
        // redirect in the same cycle as a grant and a response
        tbl.push_back(n(1,0,1, 1,32'h2008,0,32'h0));
        tbl.push_back(n(1,0,1, 1,32'h200C,0,32'h0));
        tbl.push_back(mk(0,1,1,1,1,32'h3000, 1,32'h2010,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'h3000,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'h3004,0,32'h0));
        tbl.push_back(n(0,1,1, 1,32'h3008,0,32'h0));
        tbl.push_back(n(0,1,1, 1,32'h3008,1,32'h3000));
        tbl.push_back(n(0,0,1, 1,32'h3008,1,32'h3004));
        tbl.push_back(n(0,0,1, 1,32'h3008,0,32'h0));
        // PC wrap
        tbl.push_back(mk(0,0,0,1,1,32'hFFFF_FFF8, 1,32'h3008,0,32'h0));
        tbl.push_back(n(1,0,1, 1,32'hFFFF_FFF8,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'hFFFF_FFFC,0,32'h0));
        tbl.push_back(n(1,1,1, 1,32'h0000_0000,1,32'hFFFF_FFF8));
        tbl.push_back(n(0,1,1, 1,32'h0000_0004,1,32'hFFFF_FFFC));
        tbl.push_back(n(0,0,1, 1,32'h0000_0004,1,32'h0000_0000));
        tbl.push_back(n(0,0,1, 1,32'h0000_0004,0,32'h0));
        // fill to full, reset mid-stream, then a stray response
        tbl.push_back(n(1,0,0, 1,32'h04,0,32'h0));
        tbl.push_back(n(1,1,0, 1,32'h08,0,32'h0));
        tbl.push_back(n(1,1,0, 1,32'h0C,1,32'h04));
        tbl.push_back(n(1,1,0, 1,32'h10,1,32'h04));
        tbl.push_back(n(0,1,0, 0,32'h14,1,32'h04));
        tbl.push_back(mk(1,0,0,0,0,32'h0, 0,32'h14,1,32'h04));
        tbl.push_back(mk(1,0,0,1,0,32'h0, 0,32'h100,0,32'h0));
        tbl.push_back(n(0,1,1, 1,32'h100,0,32'h0));
        tbl.push_back(n(0,0,1, 1,32'h100,0,32'h0));
        tbl.push_back(n(1,0,1, 1,32'h100,0,32'h0));
        tbl.push_back(n(0,1,1, 1,32'h104,0,32'h0));
        tbl.push_back(n(0,0,1, 1,32'h104,1,32'h100));
        tbl.push_back(n(0,0,1, 1,32'h104,0,32'h0));

        @(posedge clk_i);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Back-to-back redirects: the second reloads the drop count from the
        // in-flight total, including the grant made at the first target.
        step(n(1,0,1, 1,32'h104,0,32'h0));
        step(mk(0,1,0,1,1,32'h4000, 1,32'h108,0,32'h0));
        step(mk(0,1,1,1,1,32'h5006, 1,32'h4000,0,32'h0));
        step(n(0,1,1, 1,32'h5004,0,32'h0));
        step(n(1,1,1, 1,32'h5004,0,32'h0));
        step(n(0,1,1, 1,32'h5008,0,32'h0));
        step(n(0,0,1, 1,32'h5008,1,32'h5004));
        step(n(0,0,1, 1,32'h5008,0,32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
